// File: rtl/program_counter_stage_bp_pkg.sv
// Shared constants and types for the fetch-side program counter stage with branch prediction.
package program_counter_stage_bp_pkg;

  localparam int          DEF_ADDR_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    logic [1:0] v;
    v = cur;
    if (taken && v != 2'b11) begin
      v = v + 2'd1;
    end else if (!taken && v != 2'b00) begin
      v = v - 2'd1;
    end
    return ctr_t'(v);
  endfunction

endpackage

// File: rtl/program_counter_stage_bp_pc_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
module pc_btb
  import program_counter_stage_bp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BTB_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [BTB_DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];
  ctr_t                  ctr_q    [BTB_DEPTH];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             lookup_hit;
  logic             upd_hit;
  logic             unused_upd_bits;

  assign lookup_idx      = lookup_pc[IDX_W+1:2];
  assign lookup_tag      = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_idx         = upd_pc[IDX_W+1:2];
  assign upd_tag         = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign unused_upd_bits = ^upd_pc[1:0];

  always_comb begin
    lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    pred_taken  = lookup_valid && lookup_hit && ctr_q[lookup_idx][1];
    pred_target = pred_taken ? target_q[lookup_idx]
                             : lookup_pc + ADDR_WIDTH'(INSTR_BYTES);
  end

  // Only the valid bits need reset; payload is ignored until an entry is allocated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (upd_valid && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/program_counter_stage_bp.sv
// Fetch PC generator: resolves execute/decode redirects, follows BTB predictions, drives flushes.
module program_counter_stage_bp
  import program_counter_stage_bp_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter int                    BTB_DEPTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  STALL_PROGRAME_COUNTER_STAGE,
  input  logic                  DEC_JAL,
  input  logic [ADDR_WIDTH-1:0] PC_DECODING,
  input  logic [ADDR_WIDTH-1:0] IMM_DECODING,
  input  logic                  EX_VALID,
  input  logic                  EX_IS_JALR,
  input  logic                  EX_TAKEN,
  input  logic [ADDR_WIDTH-1:0] PC_EXECUTION,
  input  logic [ADDR_WIDTH-1:0] RS1_DATA,
  input  logic [ADDR_WIDTH-1:0] IMM_INPUT,
  input  logic                  EX_PRED_TAKEN,
  input  logic [ADDR_WIDTH-1:0] EX_PRED_TARGET,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  PC_VALID,
  output logic                  PRED_TAKEN,
  output logic [ADDR_WIDTH-1:0] PRED_TARGET,
  output logic                  CLEAR_INSTRUCTION_FETCH_STAGE,
  output logic                  CLEAR_DECODING_STAGE
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  pc_valid_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] ex_target;
  logic [ADDR_WIDTH-1:0] ex_actual;
  logic [ADDR_WIDTH-1:0] dec_target;
  logic                  ex_redirect;
  logic                  dec_redirect;
  logic                  btb_taken;
  logic [ADDR_WIDTH-1:0] btb_target;

  pc_btb #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (CLK),
    .rst_n       (RST_N),
    .lookup_valid(pc_valid_q),
    .lookup_pc   (pc_q),
    .pred_taken  (btb_taken),
    .pred_target (btb_target),
    .upd_valid   (EX_VALID),
    .upd_taken   (EX_TAKEN),
    .upd_pc      (PC_EXECUTION),
    .upd_target  (ex_target)
  );

  // JALR targets drop bit 0; a mispredict covers both wrong direction and wrong target.
  always_comb begin
    ex_target    = EX_IS_JALR ? ((RS1_DATA + IMM_INPUT) & ~ADDR_WIDTH'(1))
                              : (PC_EXECUTION + IMM_INPUT);
    ex_actual    = EX_TAKEN ? ex_target : (PC_EXECUTION + ADDR_WIDTH'(INSTR_BYTES));
    ex_redirect  = EX_VALID && ((EX_TAKEN != EX_PRED_TAKEN) ||
                                (EX_TAKEN && (ex_target != EX_PRED_TARGET)));
    dec_redirect = DEC_JAL && !ex_redirect;
    dec_target   = PC_DECODING + IMM_DECODING;
  end

  // Execute redirects override a stall, since the fetched path is already wrong.
  always_comb begin
    pc_next = pc_q;
    if (ex_redirect) begin
      pc_next = ex_actual;
    end else if (STALL_PROGRAME_COUNTER_STAGE) begin
      pc_next = pc_q;
    end else if (dec_redirect) begin
      pc_next = dec_target;
    end else if (btb_taken) begin
      pc_next = btb_target;
    end else begin
      pc_next = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else if (!pc_valid_q) begin
      pc_valid_q <= 1'b1;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_comb begin
    PC                            = pc_q;
    PC_VALID                      = pc_valid_q;
    PRED_TAKEN                    = RST_N && btb_taken;
    PRED_TARGET                   = RST_N ? btb_target : '0;
    CLEAR_INSTRUCTION_FETCH_STAGE = RST_N && (ex_redirect ||
                                    (dec_redirect && !STALL_PROGRAME_COUNTER_STAGE));
    CLEAR_DECODING_STAGE          = RST_N && ex_redirect;
  end

endmodule
